tungsten_sequencer: RTL and testbench
=====================================

# tungsten_sequencer

Programmable select sequencer for the tungsten mux network. It stores a short program of 8-bit select words and drives each word onto the network select bus in turn. After a fixed settle time it captures the 8-bit network output and hands it downstream over a valid/ready interface. It sits between the configuration/host side and the combinational mux array and turns the array into a scheduled, repeatable lookup engine.

## Interface
Parameters:
- DEPTH, 8, program entries (power of two, 2..16)
- SETTLE, 2, cycles a select word is held before capture (≥1)
- AW, $clog2(DEPTH), derived index width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- prog_we  in  1  program write strobe; ignored while busy
- prog_addr  in  AW  program write index
- prog_data  in  8  select word to store
- prog_len  in  AW+1  steps per pass, 0..DEPTH; sampled on start accept; values >DEPTH clamp to DEPTH
- start  in  1  begin sequence; accepted only in IDLE
- loop  in  1  sampled on start accept; 1 = repeat from entry 0 until abort
- abort  in  1  terminate immediately
- sel  out  8  select bus to the mux network
- net_out  in  8  mux network result
- res_valid  out  1  captured result available
- res_ready  in  1  downstream accepts result
- res_data  out  8  captured net_out
- res_idx  out  AW  program index that produced res_data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at normal completion

## Operation
- States: IDLE, DRIVE, HOLD.
- IDLE: sel=0x00, res_valid=0. start (without abort) latches prog_len and loop, sets idx=0 → DRIVE. If the latched length is 0: no steps are issued, done pulses the next cycle, and the block stays IDLE.
- DRIVE: sel=prog[idx]; settle counter runs SETTLE cycles. On the last settle cycle net_out → res_data, idx → res_idx, state → HOLD.
- HOLD: res_valid=1; sel, res_data and res_idx are stable. On res_valid&&res_ready:
  - idx<len-1: idx+1 → DRIVE.
  - Last entry with loop=1: idx=0 → DRIVE.
  - Last entry with loop=0: → IDLE; done pulses the next cycle.
- abort in any state: → IDLE next cycle, res_valid=0, sel=0x00, no done. abort wins over start and over a same-cycle handshake; that result counts as dropped.
- prog_we while busy: no effect. start while busy: no effect.
- Program memory is not reset; its contents are undefined until written.

## Timing
- Reset values: sel=0x00, res_valid=0, res_data=0x00, res_idx=0, busy=0, done=0, state IDLE.
- start accepted at cycle 0 → sel=prog[0] and busy=1 from cycle 1. Capture at the edge ending cycle SETTLE. res_valid=1 from cycle SETTLE+1.
- With res_ready held high, each step takes SETTLE+1 cycles. A pass of N steps: the final handshake occurs at cycle N·(SETTLE+1), done=1 and busy=0 at the next cycle.
- A new start is accepted in the same cycle that done is high.
- A write to prog[i] is visible to a start accepted the following cycle.
- Reset deassertion mid-run: the block restarts in IDLE; no partial result is presented.

## Structure
- Package tungsten_pkg: state encoding constants (IDLE/DRIVE/HOLD), default DEPTH and SETTLE.
- Sub-module tungsten_prog_ram: DEPTH×8 register file, one synchronous write port, one asynchronous read port indexed by idx.
- Top: FSM, settle counter, idx counter, result register.

## Test plan
- Reset: assert rst_n=0 mid-DRIVE → all outputs at reset values asynchronously; after release, busy=0 and sel=0x00.
- Basic pass, SETTLE=2: prog={0x1B,0xE4,0x00}, prog_len=3, res_ready=1, net_out = model of the network. Start at cycle 0 → sel 0x1B at cycles 1–3, 0xE4 at 4–6, 0x00 at 7–9. res_valid at cycles 3, 6, 9 with res_idx 0, 1, 2. done=1 at cycle 10.
- Backpressure: res_ready=0 for 5 cycles on idx 1 → res_valid, res_data, sel and res_idx stay stable; the next sel changes the cycle after ready rises.
- Loop and abort: prog_len=2, loop=1 → idx sequence 0,1,0,1; abort in HOLD → IDLE next cycle, res_valid=0, done never pulses.
- Edge cases: prog_len=0 → done at cycle 1, res_valid never high. Start and abort together → stays IDLE. prog_we during busy → program unchanged on readback pass.
- Length clamp and back-to-back: prog_len=DEPTH+5 → exactly DEPTH results. A start issued in the done cycle is accepted, with sel=prog[0] on the next cycle.

Source files
------------

// File: rtl/tungsten_pkg.sv
// rtl/tungsten_pkg.sv - shared state encoding and defaults for the tungsten select sequencer
package tungsten_pkg;

    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_SETTLE = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/tungsten_sequencer_if.sv
// rtl/tungsten_sequencer_if.sv - result stream carrying captured network outputs downstream
interface tungsten_sequencer_if
    import tungsten_pkg::*;
#(
    parameter int AW = $clog2(DEFAULT_DEPTH)
);

    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_data;
    logic [AW-1:0] res_idx;

    modport master (output res_valid, output res_data, output res_idx, input res_ready);
    modport slave  (input res_valid, input res_data, input res_idx, output res_ready);

endinterface

// File: rtl/tungsten_prog_ram.sv
// rtl/tungsten_prog_ram.sv - select-word program store, synchronous write and asynchronous read
module tungsten_prog_ram
    import tungsten_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Contents are deliberately not reset; the host must load the program before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tungsten_sequencer.sv
// rtl/tungsten_sequencer.sv - steps a stored select program through the mux network and streams results
module tungsten_sequencer
    import tungsten_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int SETTLE = DEFAULT_SETTLE,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          loop,
    input  logic          abort,
    output logic [7:0]    sel,
    input  logic [7:0]    net_out,
    output logic          busy,
    output logic          done,
    tungsten_sequencer_if.master res
);

    localparam int          CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic [AW:0]   len_q;
    logic          loop_q;
    logic [7:0]    data_q;
    logic [AW-1:0] ridx_q;
    logic          done_q;

    logic [7:0]    prog_rd;
    logic [AW:0]   len_clamp;
    logic          settled;
    logic          last;
    logic          load, capture, step, wrap, finish, empty;

    // Program writes are locked out while a sequence is running so the held select stays stable.
    tungsten_prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_prog (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (idx_q),
        .rdata (prog_rd)
    );

    assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign settled   = (cnt_q == CNT_LAST);
    assign last      = ({1'b0, idx_q} == (len_q - 1'b1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, step controls and bus outputs; abort overrides every other transition.
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        capture       = 1'b0;
        step          = 1'b0;
        wrap          = 1'b0;
        finish        = 1'b0;
        empty         = 1'b0;
        sel           = 8'h00;
        busy          = 1'b1;
        res.res_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    if (len_clamp == '0) begin
                        empty = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                sel = prog_rd;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (settled) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                sel           = prog_rd;
                res.res_valid = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (res.res_ready) begin
                    if (!last) begin
                        step    = 1'b1;
                        state_d = ST_DRIVE;
                    end else if (loop_q) begin
                        wrap    = 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run parameters, settle/index counters, result register and the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            loop_q <= 1'b0;
            data_q <= 8'h00;
            ridx_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish || empty;
            if (state_q == ST_DRIVE) begin
                cnt_q <= settled ? '0 : cnt_q + 1'b1;
            end
            if (load) begin
                len_q  <= len_clamp;
                loop_q <= loop;
                idx_q  <= '0;
                cnt_q  <= '0;
            end
            if (capture) begin
                data_q <= net_out;
                ridx_q <= idx_q;
            end
            if (step) begin
                idx_q <= idx_q + 1'b1;
            end
            if (wrap) begin
                idx_q <= '0;
            end
        end
    end

    assign res.res_data = data_q;
    assign res.res_idx  = ridx_q;
    assign done         = done_q;

endmodule

// File: tb/tb_tungsten_sequencer.sv
// tb/tb_tungsten_sequencer.sv - directed self-checking bench for tungsten_sequencer
module tb_tungsten_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] prog_len;
    logic       start;
    logic       loop;
    logic       abort;
    logic [7:0] sel;
    logic [7:0] net_out;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [7:0] prog_m [8];

    tungsten_sequencer_if #(.AW(3)) res_if ();

    tungsten_sequencer #(.DEPTH(8), .SETTLE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .loop      (loop),
        .abort     (abort),
        .sel       (sel),
        .net_out   (net_out),
        .busy      (busy),
        .done      (done),
        .res       (res_if)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] netf(input logic [7:0] s);
        return {s[3:0], s[7:4]} ^ 8'h5A;
    endfunction

    assign net_out = netf(sel);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_prog(input logic [2:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        prog_m[a] = d;
        tick();
        prog_we   = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_sel;
        int         nres;
        bit         seen;
        bit         vseen;

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        start = 1'b0; loop = 1'b0; abort = 1'b0; res_if.res_ready = 1'b0;
        tick(); tick();
        check("rst sel", sel, 8'h00);
        check("rst valid", res_if.res_valid, 0);
        check("rst data", res_if.res_data, 8'h00);
        check("rst idx", res_if.res_idx, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        rst_n = 1'b1;
        tick();

        write_prog(3'd0, 8'h1B);
        write_prog(3'd1, 8'hE4);
        write_prog(3'd2, 8'h00);
        for (int i = 3; i < 8; i++) write_prog(3'(i), 8'h30 + 8'(i));

        // basic pass, then a back-to-back clamped start issued in the done cycle
        prog_len = 4'd3; loop = 1'b0; start = 1'b1; res_if.res_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            exp_sel = (c <= 3) ? prog_m[0] : (c <= 6) ? prog_m[1] : (c <= 9) ? prog_m[2] : 8'h00;
            check($sformatf("basic sel c%0d", c), sel, exp_sel);
            check($sformatf("basic busy c%0d", c), busy, (c <= 9) ? 1 : 0);
            check($sformatf("basic valid c%0d", c), res_if.res_valid, (c % 3 == 0 && c <= 9) ? 1 : 0);
            check($sformatf("basic done c%0d", c), done, (c == 10) ? 1 : 0);
            if (c % 3 == 0 && c <= 9) begin
                check($sformatf("basic idx c%0d", c), res_if.res_idx, c / 3 - 1);
                check($sformatf("basic data c%0d", c), res_if.res_data, netf(prog_m[c / 3 - 1]));
            end
        end
        start = 1'b1; prog_len = 4'd13;
        tick();
        start = 1'b0;
        check("b2b sel", sel, prog_m[0]);
        check("b2b busy", busy, 1);
        nres = 0; seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            if (res_if.res_valid) begin
                check($sformatf("clamp idx %0d", nres), res_if.res_idx, nres % 8);
                nres++;
            end
            if (done) seen = 1'b1;
        end
        check("clamp done seen", seen, 1);
        check("clamp results", nres, 8);
        tick();

        // backpressure on idx 1 with a locked-out program write
        prog_len = 4'd3; start = 1'b1; res_if.res_ready = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            start = 1'b0; prog_we = 1'b0;
            if (c >= 6 && c <= 11) begin
                check($sformatf("bp valid c%0d", c), res_if.res_valid, 1);
                check($sformatf("bp idx c%0d", c), res_if.res_idx, 1);
                check($sformatf("bp sel c%0d", c), sel, 8'hE4);
                check($sformatf("bp data c%0d", c), res_if.res_data, netf(8'hE4));
            end
            if (c == 12) begin
                check("bp next sel", sel, prog_m[2]);
                check("bp next valid", res_if.res_valid, 0);
            end
            if (c == 15) check("bp done", done, 1);
            res_if.res_ready = !(c >= 6 && c <= 10);
            if (c == 7) begin
                prog_we = 1'b1; prog_addr = 3'd1; prog_data = 8'hFF;
            end
        end
        tick();

        // loop with abort in HOLD alongside a handshake
        prog_len = 4'd2; loop = 1'b1; start = 1'b1; res_if.res_ready = 1'b1; seen = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0; abort = 1'b0;
            if (done) seen = 1'b1;
            if (c <= 12) begin
                check($sformatf("loop valid c%0d", c), res_if.res_valid, (c % 3 == 0) ? 1 : 0);
                if (c % 3 == 0) check($sformatf("loop idx c%0d", c), res_if.res_idx, (c / 3 - 1) % 2);
            end
            if (c == 12) abort = 1'b1;
            if (c == 13) begin
                check("abort busy", busy, 0);
                check("abort valid", res_if.res_valid, 0);
                check("abort sel", sel, 8'h00);
            end
        end
        check("abort no done", seen, 0);
        loop = 1'b0;

        // zero-length program
        prog_len = 4'd0; start = 1'b1; vseen = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            if (res_if.res_valid) vseen = 1'b1;
            if (c == 1) begin
                check("len0 done", done, 1);
                check("len0 busy", busy, 0);
            end
            if (c == 2) check("len0 done pulse", done, 0);
        end
        check("len0 no valid", vseen, 0);

        // start together with abort
        prog_len = 4'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start+abort busy", busy, 0);
        check("start+abort sel", sel, 8'h00);
        tick();
        check("start+abort done", done, 0);

        // asynchronous reset in the middle of DRIVE
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pre-rst busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst sel", sel, 8'h00);
        check("async rst busy", busy, 0);
        check("async rst valid", res_if.res_valid, 0);
        check("async rst data", res_if.res_data, 8'h00);
        check("async rst idx", res_if.res_idx, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post-rst busy", busy, 0);
        check("post-rst sel", sel, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
